spec_lut_gain: RTL
==================

Name: spec_lut_gain

Overview:
- Per-bin spectral gain stage in the voice-changer datapath; sits directly upstream of, and drives, the LUT_2BOY single-port gain RAM (1024x16, preloaded, read-only in use).
- Accepts one complex frequency bin per handshake, fetches the gain for that bin index from the RAM, and scales real and imaginary parts by the Q1.15 gain.
- Emits scaled bins on a valid/ready stream toward the IFFT.

Parameters:
ADDR_WIDTH, 10, gain RAM address width; bin counter width
DATA_WIDTH, 16, sample and gain width (signed)
FRAME_LEN, 1024, bins per frame; must be <= 2**ADDR_WIDTH
FIFO_DEPTH, 4, output FIFO entries; must be >= 4

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
s_valid  in  1  input bin valid
s_ready  out  1  input bin accepted when s_valid & s_ready
s_re  in  DATA_WIDTH  input real part, signed
s_im  in  DATA_WIDTH  input imaginary part, signed
s_last  in  1  last bin of frame
bypass  in  1  pass bin unscaled; sampled with each accepted bin
lut_addr  out  ADDR_WIDTH  gain RAM address, combinational = bin_cnt
lut_wr_en  out  1  gain RAM write enable, constant 0
lut_rd_data  in  DATA_WIDTH  gain RAM read data, signed Q1.15, valid one cycle after the address edge
m_valid  out  1  output bin valid
m_ready  in  1  downstream ready
m_re  out  DATA_WIDTH  scaled real part
m_im  out  DATA_WIDTH  scaled imaginary part
m_last  out  1  last bin of frame
m_bin  out  ADDR_WIDTH  bin index of the output bin
frame_err  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset (asynchronous, active-high): bin_cnt=0, all pipeline valids=0, FIFO empty. Outputs go to s_ready=0 during reset, then 1; m_valid=0; m_re/m_im/m_bin=0; m_last=0; frame_err=0. In-flight bins are discarded.
- Pipeline, with acceptance at the edge ending cycle N:
  - Edge N: the RAM captures lut_addr; P1 registers re, im, last, bypass and bin.
  - Cycle N+1: gain = lut_rd_data. Multiply, round and saturate.
  - Edge N+1: P2 registers the results.
  - Edge N+2: FIFO write (first-word-fall-through).
  - Result: m_valid is high in cycle N+3 when the FIFO was empty.
- Pipeline stages P1 and P2 never stall. Flow control is credit based:
  - s_ready = (fifo_count + v_p1 + v_p2) < FIFO_DEPTH.
  - This is derived from registers only, with no combinational path from m_ready.
- Full throughput is required: with m_ready=1, s_ready stays 1 indefinitely.
- Arithmetic:
  - Compute p = x*g as a signed 2*DATA_WIDTH product.
  - y = (p + 2^14) >>> 15 (round half up).
  - Saturate y to [-32768, 32767]. The only overflow case is x = g = -32768, which gives 32767.
  - Real and imaginary parts are processed identically with the same gain.
- bypass=1: m_re=s_re and m_im=s_im bit-exact, and lut_rd_data is ignored. The RAM is still addressed and bin_cnt still advances.
- Bin counter (advances only on an accepted bin):
  - If s_last=1 and bin_cnt=FRAME_LEN-1: next bin_cnt=0, no error.
  - If s_last=1 and bin_cnt!=FRAME_LEN-1 (early last): bin_cnt->0 and frame_err pulses the next cycle.
  - If s_last=0 and bin_cnt=FRAME_LEN-1 (missing last): bin_cnt->0 (wrap) and frame_err pulses the next cycle.
  - In all other cases: bin_cnt+1.
- Errors never drop data. The bin is processed and s_last is forwarded unchanged to m_last.
- Output handshake: while m_valid=1 and m_ready=0, m_re, m_im, m_last and m_bin hold stable. A FIFO pop happens on m_valid & m_ready. Simultaneous FIFO push and pop leaves the count unchanged.
- s_valid without s_ready: no state change, and lut_addr still shows bin_cnt.
- An X on lut_rd_data while P1 is invalid must not propagate to the outputs.

Decomposition:
- Shared package spec_pkg contains:
  - Q15_ROUND = 2^14 and Q15_SHIFT = 15;
  - the saturation limits SAT_MAX = 32767 and SAT_MIN = -32768;
  - the default FRAME_LEN;
  - a function sat_round_q15.
- Sub-module spec_out_fifo: a synchronous first-word-fall-through FIFO, FIFO_DEPTH entries wide enough for {last, bin, im, re}. It exposes count, asynchronous active-high rst, and pointers that wrap modulo FIFO_DEPTH.

Test Plan:
- Full frame, RAM initialised with gain[k]=0x4000 for all k, s_re=s_im=257, m_ready=1 -> 1024 outputs, each m_re=m_im=129, m_bin=0..1023, m_last only on bin 1023. Latency is 3 cycles from first acceptance, throughput 1 per cycle, frame_err never asserted.
- Gain 0x7FFF at bin 0 with s_re=0x4000, s_im=0x8000 (-32768) -> m_re=0x4000, m_im=0x8001. Gain 0x8000 with s_re=0x8000 -> m_re=0x7FFF (saturated).
- bypass=1 with arbitrary gains, s_re=0x1234, s_im=0xFEDC -> outputs bit-exact equal to the inputs, and bin_cnt still advances.
- Backpressure: m_ready=0 for 10 cycles with s_valid=1 -> s_ready falls after exactly 4 accepted bins. Held outputs stay stable. On m_ready=1, all bins drain in order with none lost or duplicated.
- Early s_last at bin 5 -> frame_err pulses one cycle. The next accepted bin has m_bin=0. Bin 1023 without s_last -> frame_err pulses, and the counter wraps to 0.
- rst asserted mid-frame with 3 bins in flight -> m_valid=0 immediately (asynchronous). After release, the first output has m_bin=0 and no stale bins appear.

Source files
------------

// File: rtl/spec_lut_gain_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spec_pkg
//  Brief    : Shared Q1.15 constants and the round/saturate helper for the
//             per-bin spectral gain stage.
//  Revision : 1.0
// ============================================================================
package spec_pkg;

    localparam int Q15_ROUND         = 2**14;
    localparam int Q15_SHIFT         = 15;
    localparam int SAT_MAX           = 32767;
    localparam int SAT_MIN           = -32768;
    localparam int DEFAULT_FRAME_LEN = 1024;

    // Round half up on the Q2.30 product, then clamp to Q1.15; only
    // (-1.0 * -1.0) can exceed the positive limit.
    function automatic logic signed [15:0] sat_round_q15(input logic signed [31:0] p);
        logic signed [32:0] w_sum;
        logic signed [32:0] w_y;
        w_sum = 33'(p) + 33'(Q15_ROUND);
        w_y   = w_sum >>> Q15_SHIFT;
        if (w_y > 33'(SAT_MAX)) begin
            return 16'(SAT_MAX);
        end else if (w_y < 33'(SAT_MIN)) begin
            return 16'(SAT_MIN);
        end else begin
            return w_y[15:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/spec_lut_gain_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : spec_out_fifo
//  Brief    : Synchronous first-word-fall-through FIFO with occupancy count.
//  Revision : 1.0
// ============================================================================
module spec_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 43
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_din,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_dout,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_full;
    logic               w_push;
    logic               w_pop;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == c_full_cnt);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~w_full | w_pop);
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spec_lut_gain.sv
`default_nettype none
// ============================================================================
//  Module   : spec_lut_gain
//  Brief    : Per-bin complex gain from an external Q1.15 gain RAM, with a
//             credit-controlled two-stage pipeline and FWFT output FIFO.
//  Revision : 1.0
// ============================================================================
module spec_lut_gain
    import spec_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = DEFAULT_FRAME_LEN,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_re,
    input  logic [DATA_WIDTH-1:0] s_im,
    input  logic                  s_last,
    input  logic                  bypass,
    output logic [ADDR_WIDTH-1:0] lut_addr,
    output logic                  lut_wr_en,
    input  logic [DATA_WIDTH-1:0] lut_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_re,
    output logic [DATA_WIDTH-1:0] m_im,
    output logic                  m_last,
    output logic [ADDR_WIDTH-1:0] m_bin,
    output logic                  frame_err
);

    localparam int c_entry_w = 1 + ADDR_WIDTH + 2 * DATA_WIDTH;
    localparam int c_cnt_w   = $clog2(FIFO_DEPTH + 1);
    localparam int c_used_w  = c_cnt_w + 2;
    localparam logic [ADDR_WIDTH-1:0] c_last_bin = ADDR_WIDTH'(FRAME_LEN - 1);
    localparam logic [c_used_w-1:0]   c_credits  = c_used_w'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0]          r_bin_cnt;
    logic                           r_frame_err;

    logic                           r_p1_v;
    logic                           r_p1_last;
    logic                           r_p1_byp;
    logic signed [DATA_WIDTH-1:0]   r_p1_re;
    logic signed [DATA_WIDTH-1:0]   r_p1_im;
    logic [ADDR_WIDTH-1:0]          r_p1_bin;

    logic                           r_p2_v;
    logic                           r_p2_last;
    logic [DATA_WIDTH-1:0]          r_p2_re;
    logic [DATA_WIDTH-1:0]          r_p2_im;
    logic [ADDR_WIDTH-1:0]          r_p2_bin;

    logic                           w_accept;
    logic                           w_at_end;
    logic signed [DATA_WIDTH-1:0]   w_gain;
    logic signed [2*DATA_WIDTH-1:0] w_prod_re;
    logic signed [2*DATA_WIDTH-1:0] w_prod_im;
    logic [DATA_WIDTH-1:0]          w_y_re;
    logic [DATA_WIDTH-1:0]          w_y_im;
    logic [c_cnt_w-1:0]             w_fifo_count;
    logic                           w_fifo_empty;
    logic [c_entry_w-1:0]           w_fifo_din;
    logic [c_entry_w-1:0]           w_fifo_dout;
    logic [c_used_w-1:0]            w_used;

    // Credits cover every bin already in the pipe, so P1/P2 never need to stall.
    assign w_used   = c_used_w'(w_fifo_count) + c_used_w'(r_p1_v) + c_used_w'(r_p2_v);
    assign s_ready  = ~rst & (w_used < c_credits);
    assign w_accept = s_valid & s_ready;
    assign w_at_end = (r_bin_cnt == c_last_bin);

    assign lut_addr  = r_bin_cnt;
    assign lut_wr_en = 1'b0;
    assign frame_err = r_frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin_cnt   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (w_accept) begin
                r_bin_cnt   <= (s_last | w_at_end) ? '0 : r_bin_cnt + 1'b1;
                r_frame_err <= s_last ^ w_at_end;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1_v    <= 1'b0;
            r_p1_last <= 1'b0;
            r_p1_byp  <= 1'b0;
            r_p1_re   <= '0;
            r_p1_im   <= '0;
            r_p1_bin  <= '0;
        end else begin
            r_p1_v <= w_accept;
            if (w_accept) begin
                r_p1_last <= s_last;
                r_p1_byp  <= bypass;
                r_p1_re   <= s_re;
                r_p1_im   <= s_im;
                r_p1_bin  <= r_bin_cnt;
            end
        end
    end

    assign w_gain    = lut_rd_data;
    assign w_prod_re = (2*DATA_WIDTH)'(r_p1_re) * (2*DATA_WIDTH)'(w_gain);
    assign w_prod_im = (2*DATA_WIDTH)'(r_p1_im) * (2*DATA_WIDTH)'(w_gain);
    assign w_y_re    = r_p1_byp ? r_p1_re : sat_round_q15(w_prod_re);
    assign w_y_im    = r_p1_byp ? r_p1_im : sat_round_q15(w_prod_im);

    // P2 only loads behind a valid P1, so idle-cycle RAM data never reaches the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p2_v    <= 1'b0;
            r_p2_last <= 1'b0;
            r_p2_re   <= '0;
            r_p2_im   <= '0;
            r_p2_bin  <= '0;
        end else begin
            r_p2_v <= r_p1_v;
            if (r_p1_v) begin
                r_p2_last <= r_p1_last;
                r_p2_re   <= w_y_re;
                r_p2_im   <= w_y_im;
                r_p2_bin  <= r_p1_bin;
            end
        end
    end

    assign w_fifo_din = {r_p2_last, r_p2_bin, r_p2_im, r_p2_re};

    spec_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_entry_w)
    ) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_p2_v),
        .i_din   (w_fifo_din),
        .i_pop   (m_valid & m_ready),
        .o_dout  (w_fifo_dout),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    assign m_valid = ~w_fifo_empty;
    assign {m_last, m_bin, m_im, m_re} = m_valid ? w_fifo_dout : '0;

endmodule
`default_nettype wire
